// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI register sequencer: state encoding, driver
// command codes, default limits and the address-byte framing helper.
package spi_seq_pkg;

    typedef enum logic [3:0] {
        ST_FLUSH   = 4'd0,
        ST_IDLE    = 4'd1,
        ST_PUSH0   = 4'd2,
        ST_PUSH1   = 4'd3,
        ST_WAIT_HI = 4'd4,
        ST_WAIT_LO = 4'd5,
        ST_POP     = 4'd6,
        ST_CAP     = 4'd7,
        ST_RESP    = 4'd8
    } seq_state_t;

    localparam logic [1:0] CMD_TX = 2'b01;
    localparam logic [1:0] CMD_RX = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
    localparam int DEFAULT_FLUSH_POPS     = 16;
    localparam int QUIET_CYCLES           = 8;

    // Address byte as seen on the bus: register address with the r/w flag
    // overlaid at the configured bit position.
    function automatic logic [7:0] frame_addr_byte(
        input logic       write,
        input logic [6:0] addr,
        input logic [2:0] flag_pos,
        input logic       write_polarity
    );
        logic [7:0] b;
        b           = {1'b0, addr};
        b[flag_pos] = write ? write_polarity : ~write_polarity;
        return b;
    endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the last permitted cycle so the FSM leaves on exactly TIMEOUT_CYCLES.
module spi_seq_timer
    import spi_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && !done) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign done = (count_reg == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/spi_reg_sequencer.sv
// Turns single register read/write requests into SPI driver FIFO pushes, one
// chip-select transaction per request, and returns one response per request.
module spi_reg_sequencer
    import spi_seq_pkg::*;
#(
    parameter int   WR_BIT_POS     = 7,
    parameter logic WR_POLARITY    = 1'b1,
    parameter int   TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int   FLUSH_POPS     = DEFAULT_FLUSH_POPS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    input  logic       spi_busy,
    output logic       spi_cmd_push,
    output logic [1:0] spi_cmd,
    output logic       spi_tx_push,
    output logic [7:0] spi_tx_byte,
    output logic       spi_rx_pop,
    input  logic [7:0] spi_rx_byte,
    output logic [3:0] seq_state
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int PW = $clog2(FLUSH_POPS + 1);

    seq_state_t state_reg, state_next;
    logic          write_reg, write_next;
    logic [6:0]    addr_reg, addr_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic [QW-1:0] quiet_reg, quiet_next;
    logic [PW-1:0] pops_reg, pops_next;

    logic       cmd_push_reg, cmd_push_next;
    logic [1:0] cmd_reg, cmd_next;
    logic       tx_push_reg, tx_push_next;
    logic [7:0] tx_byte_reg, tx_byte_next;
    logic       rx_pop_reg, rx_pop_next;
    logic       resp_valid_reg, resp_valid_next;
    logic [7:0] resp_rdata_reg, resp_rdata_next;
    logic       resp_err_reg, resp_err_next;

    logic tm_clear, tm_enable, tm_done;

    spi_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tm_clear),
        .enable (tm_enable),
        .done   (tm_done)
    );

    // Timer restarts on every wait-state entry, including WAIT_HI -> WAIT_LO.
    assign tm_enable = (state_reg == ST_WAIT_HI) || (state_reg == ST_WAIT_LO);
    assign tm_clear  = !tm_enable || ((state_reg == ST_WAIT_HI) && spi_busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_FLUSH;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            quiet_reg      <= '0;
            pops_reg       <= '0;
            cmd_push_reg   <= 1'b0;
            cmd_reg        <= '0;
            tx_push_reg    <= 1'b0;
            tx_byte_reg    <= '0;
            rx_pop_reg     <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            write_reg      <= write_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            quiet_reg      <= quiet_next;
            pops_reg       <= pops_next;
            cmd_push_reg   <= cmd_push_next;
            cmd_reg        <= cmd_next;
            tx_push_reg    <= tx_push_next;
            tx_byte_reg    <= tx_byte_next;
            rx_pop_reg     <= rx_pop_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_err_reg   <= resp_err_next;
        end
    end

    // Strobes are computed for the state being entered and registered, so
    // each pulse lines up exactly with the cycle spent in that state.
    always_comb begin
        state_next      = state_reg;
        write_next      = write_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        quiet_next      = quiet_reg;
        pops_next       = pops_reg;
        cmd_push_next   = 1'b0;
        cmd_next        = cmd_reg;
        tx_push_next    = 1'b0;
        tx_byte_next    = tx_byte_reg;
        rx_pop_next     = 1'b0;
        resp_valid_next = 1'b0;
        resp_rdata_next = resp_rdata_reg;
        resp_err_next   = resp_err_reg;

        case (state_reg)
            ST_FLUSH: begin
                if (quiet_reg != QW'(QUIET_CYCLES)) begin
                    quiet_next = spi_busy ? '0 : quiet_reg + 1'b1;
                end else if (pops_reg != PW'(FLUSH_POPS)) begin
                    rx_pop_next = 1'b1;
                    pops_next   = pops_reg + 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    quiet_next = '0;
                    pops_next  = '0;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    state_next    = ST_PUSH0;
                    write_next    = req_write;
                    addr_next     = req_addr;
                    wdata_next    = req_wdata;
                    tx_push_next  = 1'b1;
                    tx_byte_next  = frame_addr_byte(req_write, req_addr,
                                                    3'(WR_BIT_POS), WR_POLARITY);
                    cmd_push_next = 1'b1;
                    cmd_next      = CMD_TX;
                end
            end
            ST_PUSH0: begin
                state_next    = ST_PUSH1;
                cmd_push_next = 1'b1;
                cmd_next      = write_reg ? CMD_TX : CMD_RX;
                if (write_reg) begin
                    tx_push_next = 1'b1;
                    tx_byte_next = wdata_reg;
                end
            end
            ST_PUSH1: begin
                state_next = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (spi_busy) begin
                    state_next = ST_WAIT_LO;
                end else if (tm_done) begin
                    state_next      = ST_RESP;
                    resp_valid_next = 1'b1;
                    resp_err_next   = 1'b1;
                    resp_rdata_next = 8'h00;
                end
            end
            ST_WAIT_LO: begin
                if (!spi_busy) begin
                    if (write_reg) begin
                        state_next      = ST_RESP;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b0;
                        resp_rdata_next = 8'h00;
                    end else begin
                        state_next  = ST_POP;
                        rx_pop_next = 1'b1;
                    end
                end else if (tm_done) begin
                    state_next      = ST_RESP;
                    resp_valid_next = 1'b1;
                    resp_err_next   = 1'b1;
                    resp_rdata_next = 8'h00;
                end
            end
            ST_POP: begin
                state_next = ST_CAP;
            end
            ST_CAP: begin
                state_next      = ST_RESP;
                resp_valid_next = 1'b1;
                resp_err_next   = 1'b0;
                resp_rdata_next = spi_rx_byte;
            end
            ST_RESP: begin
                state_next = resp_err_reg ? ST_FLUSH : ST_IDLE;
            end
            default: begin
                state_next = ST_FLUSH;
            end
        endcase
    end

    assign req_ready    = (state_reg == ST_IDLE);
    assign resp_valid   = resp_valid_reg;
    assign resp_rdata   = resp_rdata_reg;
    assign resp_err     = resp_err_reg;
    assign spi_cmd_push = cmd_push_reg;
    assign spi_cmd      = cmd_reg;
    assign spi_tx_push  = tx_push_reg;
    assign spi_tx_byte  = tx_byte_reg;
    assign spi_rx_pop   = rx_pop_reg;
    assign seq_state    = state_reg;

endmodule
